// File: rtl/dict_scan.sv
// dict_scan: key/value dictionary for the Forth word table.
// Each request is serviced by a banked scan. Every cycle, LANES slots are compared,
// so a key op always takes SCAN = ceil(ENTRIES/LANES) cycles.
// Ports:
//   i_clk, i_rst           clock, asynchronous active-high reset
//   i_valid / o_ready      request handshake (accept when both high)
//   i_op                   0 SET,1 GET,2 ENCODE,3 DELETE,4 SET_IDX,5 GET_IDX,6 DEL_IDX,7 CLEAR
//   i_key, i_index, i_value request operands
//   o_valid                one-cycle response strobe
//   o_value, o_index, o_err response (held between strobes)
//   o_count, o_full        occupancy

// One comparator lane: match against a valid slot, or report a free slot.
module dict_scan_lane #(
    parameter int KEY_BITS = 32
) (
    input  logic                in_range,
    input  logic                slot_vld,
    input  logic [KEY_BITS-1:0] slot_key,
    input  logic [KEY_BITS-1:0] req_key,
    output logic                hit,
    output logic                free
);
    assign hit  = in_range & slot_vld & (slot_key == req_key);
    assign free = in_range & ~slot_vld;
endmodule

module dict_scan #(
    parameter int ENTRIES      = 16,
    parameter int KEY_WIDTH    = 8,
    parameter int KEY_LENGTH   = 4,
    parameter int VALUE_WIDTH  = 32,
    parameter int VALUE_LENGTH = 1,
    parameter int LANES        = 4,
    parameter int IDX_BITS     = $clog2(ENTRIES)
) (
    input  logic                                i_clk,
    input  logic                                i_rst,
    input  logic                                i_valid,
    output logic                                o_ready,
    input  logic [2:0]                          i_op,
    input  logic [KEY_WIDTH*KEY_LENGTH-1:0]     i_key,
    input  logic [IDX_BITS-1:0]                 i_index,
    input  logic [VALUE_WIDTH*VALUE_LENGTH-1:0] i_value,
    output logic                                o_valid,
    output logic [VALUE_WIDTH*VALUE_LENGTH-1:0] o_value,
    output logic [IDX_BITS-1:0]                 o_index,
    output logic [1:0]                          o_err,
    output logic [IDX_BITS:0]                   o_count,
    output logic                                o_full
);
    localparam int KEY_BITS   = KEY_WIDTH * KEY_LENGTH;
    localparam int VALUE_BITS = VALUE_WIDTH * VALUE_LENGTH;
    localparam int SCAN       = (ENTRIES + LANES - 1) / LANES;
    localparam int PTR_W      = (SCAN > 1) ? $clog2(SCAN) : 1;
    localparam int SLOT_W     = $clog2(SCAN * LANES + 1);
    localparam int CNT_W      = IDX_BITS + 1;

    localparam logic [2:0] OP_SET = 3'd0, OP_GET = 3'd1, OP_ENC = 3'd2, OP_DEL = 3'd3;
    localparam logic [2:0] OP_SIDX = 3'd4, OP_GIDX = 3'd5, OP_DIDX = 3'd6, OP_CLR = 3'd7;
    localparam logic [1:0] ERR_OK = 2'd0, ERR_NF = 2'd1, ERR_FULL = 2'd2, ERR_BAD = 2'd3;

    typedef struct packed {
        logic [2:0]            op;
        logic [KEY_BITS-1:0]   key;
        logic [IDX_BITS-1:0]   index;
        logic [VALUE_BITS-1:0] value;
    } req_t;

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_RESP} state_t;

    state_t                             state, state_nxt;
    req_t                               req;
    logic [PTR_W-1:0]                   ptr;
    logic                               m_found, f_found;
    logic [IDX_BITS-1:0]                m_idx, f_idx;
    logic [ENTRIES-1:0]                 vld;
    logic [ENTRIES-1:0][KEY_BITS-1:0]   keys;
    logic [ENTRIES-1:0][VALUE_BITS-1:0] vals;
    logic [VALUE_BITS-1:0]              hold_value;
    logic [IDX_BITS-1:0]                hold_index;
    logic [1:0]                         hold_err;
    logic [CNT_W-1:0]                   count;

    logic [LANES-1:0]                   hit, free;
    logic [LANES-1:0][IDX_BITS-1:0]     lidx;
    logic                               c_hit, c_free;
    logic [IDX_BITS-1:0]                c_hidx, c_fidx;

    logic [VALUE_BITS-1:0]              r_value;
    logic [IDX_BITS-1:0]                r_index;
    logic [1:0]                         r_err;
    logic [CNT_W-1:0]                   cnt_nxt;
    logic                               wr_en, set_vld, clr_vld, clr_all;
    logic [IDX_BITS-1:0]                wr_idx;
    logic                               idx_ok;

    // Lanes past the last slot (partial final bank) are masked out.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [SLOT_W-1:0] slot;
        logic              in_rng;
        assign slot    = SLOT_W'(ptr) * SLOT_W'(LANES) + SLOT_W'(l);
        assign in_rng  = slot < SLOT_W'(ENTRIES);
        assign lidx[l] = in_rng ? IDX_BITS'(slot) : '0;
        dict_scan_lane #(.KEY_BITS(KEY_BITS)) u_lane (
            .in_range (in_rng),
            .slot_vld (vld[lidx[l]]),
            .slot_key (keys[lidx[l]]),
            .req_key  (req.key),
            .hit      (hit[l]),
            .free     (free[l])
        );
    end

    // Lowest lane wins within a bank; banks are visited in ascending order,
    // so the first recorded hit is the lowest slot overall.
    always_comb begin
        c_hit  = 1'b0;
        c_hidx = '0;
        c_free = 1'b0;
        c_fidx = '0;
        for (int l = LANES - 1; l >= 0; l--) begin
            if (hit[l])  begin c_hit  = 1'b1; c_hidx = lidx[l]; end
            if (free[l]) begin c_free = 1'b1; c_fidx = lidx[l]; end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (i_valid) state_nxt = i_op[2] ? S_RESP : S_SCAN;
            S_SCAN:  if (ptr == PTR_W'(SCAN - 1)) state_nxt = S_RESP;
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign idx_ok = {1'b0, req.index} < CNT_W'(ENTRIES);

    // Response and write decisions.
    // Outside RESP, every field falls back to the held values.
    always_comb begin
        r_value = hold_value;
        r_index = hold_index;
        r_err   = hold_err;
        cnt_nxt = count;
        wr_en   = 1'b0;
        set_vld = 1'b0;
        clr_vld = 1'b0;
        clr_all = 1'b0;
        wr_idx  = '0;
        if (state == S_RESP) begin
            case (req.op)
                OP_SET: begin
                    if (m_found) begin
                        wr_en = 1'b1; wr_idx = m_idx; r_index = m_idx; r_err = ERR_OK;
                    end else if (f_found) begin
                        wr_en = 1'b1; set_vld = 1'b1; wr_idx = f_idx;
                        r_index = f_idx; r_err = ERR_OK; cnt_nxt = count + CNT_W'(1);
                    end else begin
                        r_index = '0; r_err = ERR_FULL;
                    end
                end
                OP_GET: begin
                    r_value = m_found ? vals[m_idx] : '0;
                    r_index = m_found ? m_idx : '0;
                    r_err   = m_found ? ERR_OK : ERR_NF;
                end
                OP_ENC: begin
                    r_index = m_found ? m_idx : '0;
                    r_err   = m_found ? ERR_OK : ERR_NF;
                end
                OP_DEL: begin
                    r_value = m_found ? vals[m_idx] : '0;
                    r_index = m_found ? m_idx : '0;
                    r_err   = m_found ? ERR_OK : ERR_NF;
                    if (m_found) begin
                        clr_vld = 1'b1; wr_idx = m_idx; cnt_nxt = count - CNT_W'(1);
                    end
                end
                OP_CLR: begin
                    clr_all = 1'b1; cnt_nxt = '0; r_index = '0; r_err = ERR_OK;
                end
                default: begin
                    // Index ops
                    r_index = req.index;
                    if (!idx_ok) begin
                        r_err = ERR_BAD;
                    end else begin
                        wr_idx = req.index;
                        case (req.op)
                            OP_SIDX: begin
                                wr_en = 1'b1; set_vld = 1'b1; r_err = ERR_OK;
                                if (!vld[req.index]) cnt_nxt = count + CNT_W'(1);
                            end
                            OP_GIDX: begin
                                r_value = vals[req.index];
                                r_err   = vld[req.index] ? ERR_OK : ERR_NF;
                            end
                            default: begin
                                r_value = vals[req.index];
                                r_err   = vld[req.index] ? ERR_OK : ERR_NF;
                                if (vld[req.index]) begin
                                    clr_vld = 1'b1; cnt_nxt = count - CNT_W'(1);
                                end
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            req        <= '0;
            ptr        <= '0;
            m_found    <= 1'b0;
            m_idx      <= '0;
            f_found    <= 1'b0;
            f_idx      <= '0;
            vld        <= '0;
            hold_value <= '0;
            hold_index <= '0;
            hold_err   <= '0;
            count      <= '0;
        end else begin
            case (state)
                S_IDLE: if (i_valid) begin
                    req     <= {i_op, i_key, i_index, i_value};
                    ptr     <= '0;
                    m_found <= 1'b0;
                    f_found <= 1'b0;
                end
                S_SCAN: begin
                    ptr <= ptr + PTR_W'(1);
                    if (!m_found && c_hit)  begin m_found <= 1'b1; m_idx <= c_hidx; end
                    if (!f_found && c_free) begin f_found <= 1'b1; f_idx <= c_fidx; end
                end
                S_RESP: begin
                    hold_value <= r_value;
                    hold_index <= r_index;
                    hold_err   <= r_err;
                    count      <= cnt_nxt;
                    if (clr_all)      vld         <= '0;
                    else if (set_vld) vld[wr_idx] <= 1'b1;
                    else if (clr_vld) vld[wr_idx] <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Key/value storage is not reset. The valid bits alone decide occupancy.
    always_ff @(posedge i_clk) begin
        if (state == S_RESP && wr_en) begin
            keys[wr_idx] <= req.key;
            vals[wr_idx] <= req.value;
        end
    end

    assign o_ready = (state == S_IDLE);
    assign o_valid = (state == S_RESP);
    assign o_value = r_value;
    assign o_index = r_index;
    assign o_err   = r_err;
    assign o_count = cnt_nxt;
    assign o_full  = (cnt_nxt == CNT_W'(ENTRIES));
endmodule

// File: tb/tb_dict_scan.sv
module tb_dict_scan;
    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_valid;
    logic        o_ready;
    logic [2:0]  i_op;
    logic [31:0] i_key;
    logic [3:0]  i_index;
    logic [31:0] i_value;
    logic        o_valid;
    logic [31:0] o_value;
    logic [3:0]  o_index;
    logic [1:0]  o_err;
    logic [4:0]  o_count;
    logic        o_full;

    int errors = 0;
    int checks = 0;

    dict_scan #(.ENTRIES(10), .LANES(4)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_op(i_op), .i_key(i_key), .i_index(i_index), .i_value(i_value),
        .o_valid(o_valid), .o_value(o_value), .o_index(o_index), .o_err(o_err),
        .o_count(o_count), .o_full(o_full)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] key;
        logic [3:0]  idx;
        logic [31:0] val;
        logic [31:0] e_val;
        logic [3:0]  e_idx;
        logic [1:0]  e_err;
        logic [4:0]  e_cnt;
        int          e_lat;
        bit          cv;
        bit          ci;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [31:0] k(input string s);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = s[i];
        return r;
    endfunction

    task automatic add(input logic [2:0] op, input logic [31:0] key, input logic [3:0] idx,
                       input logic [31:0] val, input logic [31:0] ev, input logic [3:0] ei,
                       input logic [1:0] ee, input logic [4:0] ec, input int el,
                       input bit cv, input bit ci);
        vec_t v;
        v.op = op; v.key = key; v.idx = idx; v.val = val;
        v.e_val = ev; v.e_idx = ei; v.e_err = ee; v.e_cnt = ec; v.e_lat = el;
        v.cv = cv; v.ci = ci;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
        end
    endtask

    task automatic run(input vec_t v, input int n);
        int w;
        int lat;
        w = 0;
        @(negedge i_clk);
        while (!o_ready && w < 50) begin @(negedge i_clk); w++; end
        chk($sformatf("v%0d_ready", n), o_ready, 1);
        i_valid = 1'b1; i_op = v.op; i_key = v.key; i_index = v.idx; i_value = v.val;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        lat = 1;
        while (!o_valid && lat < 50) begin @(posedge i_clk); #1; lat++; end
        chk($sformatf("v%0d_lat", n), lat, v.e_lat);
        chk($sformatf("v%0d_err", n), o_err, v.e_err);
        chk($sformatf("v%0d_cnt", n), o_count, v.e_cnt);
        chk($sformatf("v%0d_full", n), o_full, (v.e_cnt == 5'd10));
        if (v.ci) chk($sformatf("v%0d_idx", n), o_index, v.e_idx);
        if (v.cv) chk($sformatf("v%0d_val", n), o_value, v.e_val);
        @(posedge i_clk); #1;
        chk($sformatf("v%0d_strobe", n), o_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t v;
        int acc;
        int strb;
        bit seen;
        i_rst = 1'b1; i_valid = 1'b0; i_op = '0; i_key = '0; i_index = '0; i_value = '0;
        repeat (3) @(posedge i_clk);
        #1;
        chk("rst_ready", o_ready, 1);
        chk("rst_valid", o_valid, 0);
        chk("rst_value", o_value, 0);
        chk("rst_index", o_index, 0);
        chk("rst_err", o_err, 0);
        chk("rst_count", o_count, 0);
        chk("rst_full", o_full, 0);
        @(negedge i_clk);
        i_rst = 1'b0;

        //   op    key           idx   val       e_val     ei    ee    ec     lat cv ci
        add(3'd1, k("DUP "),    4'd0, 32'h0,    32'h0,    4'd0, 2'd1, 5'd0,  4, 1, 1);
        add(3'd0, k("DUP "),    4'd0, 32'h11,   32'h0,    4'd0, 2'd0, 5'd1,  4, 0, 1);
        add(3'd0, k("DROP"),    4'd0, 32'h22,   32'h0,    4'd1, 2'd0, 5'd2,  4, 0, 1);
        add(3'd1, k("DROP"),    4'd0, 32'h0,    32'h22,   4'd1, 2'd0, 5'd2,  4, 1, 1);
        add(3'd0, k("DUP "),    4'd0, 32'h33,   32'h0,    4'd0, 2'd0, 5'd2,  4, 0, 1);
        add(3'd1, k("DUP "),    4'd0, 32'h0,    32'h33,   4'd0, 2'd0, 5'd2,  4, 1, 1);
        for (int i = 2; i < 10; i++)
            add(3'd0, 32'h4B00 + i, 4'd0, 32'h100 + i, 32'h0, 4'(i), 2'd0, 5'(i + 1), 4, 0, 1);
        add(3'd0, k("SWAP"),    4'd0, 32'h44,   32'h0,    4'd0, 2'd2, 5'd10, 4, 0, 0);
        add(3'd3, 32'h4B05,     4'd0, 32'h0,    32'h105,  4'd5, 2'd0, 5'd9,  4, 1, 1);
        add(3'd0, k("SWAP"),    4'd0, 32'h44,   32'h0,    4'd5, 2'd0, 5'd10, 4, 0, 1);
        add(3'd1, k("SWAP"),    4'd0, 32'h0,    32'h44,   4'd5, 2'd0, 5'd10, 4, 1, 1);
        add(3'd5, 32'h0,        4'd12, 32'h0,   32'h0,    4'd0, 2'd3, 5'd10, 1, 0, 0);
        add(3'd6, 32'h0,        4'd3, 32'h0,    32'h103,  4'd3, 2'd0, 5'd9,  1, 1, 1);
        add(3'd6, 32'h0,        4'd3, 32'h0,    32'h103,  4'd3, 2'd1, 5'd9,  1, 1, 1);
        add(3'd4, k("EMIT"),    4'd7, 32'h55,   32'h0,    4'd7, 2'd0, 5'd9,  1, 0, 1);
        add(3'd4, k("EMIT"),    4'd2, 32'h66,   32'h0,    4'd2, 2'd0, 5'd9,  1, 0, 1);
        add(3'd2, k("EMIT"),    4'd0, 32'h0,    32'h0,    4'd2, 2'd0, 5'd9,  4, 0, 1);
        add(3'd5, 32'h0,        4'd3, 32'h0,    32'h103,  4'd3, 2'd1, 5'd9,  1, 1, 1);
        add(3'd4, 32'h4B03,     4'd3, 32'h203,  32'h0,    4'd3, 2'd0, 5'd10, 1, 0, 1);
        add(3'd1, 32'h4B03,     4'd0, 32'h0,    32'h203,  4'd3, 2'd0, 5'd10, 4, 1, 1);
        add(3'd1, k("EMIT"),    4'd0, 32'h0,    32'h66,   4'd2, 2'd0, 5'd10, 4, 1, 1);
        add(3'd3, k("DUP "),    4'd0, 32'h0,    32'h33,   4'd0, 2'd0, 5'd9,  4, 1, 1);
        add(3'd3, k("DUP "),    4'd0, 32'h0,    32'h0,    4'd0, 2'd1, 5'd9,  4, 0, 0);
        add(3'd7, 32'h0,        4'd0, 32'h0,    32'h0,    4'd0, 2'd0, 5'd0,  1, 0, 1);
        add(3'd1, k("EMIT"),    4'd0, 32'h0,    32'h0,    4'd0, 2'd1, 5'd0,  4, 1, 1);

        for (int n = 0; n < vecs.size(); n++) run(vecs[n], n);

        // Reset during the second scan cycle of a SET aborts it cleanly
        @(negedge i_clk);
        i_valid = 1'b1; i_op = 3'd0; i_key = k("ZAP "); i_value = 32'h77;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        @(posedge i_clk); #1;
        i_rst = 1'b1;
        #1;
        chk("midrst_ready_async", o_ready, 1);
        @(negedge i_clk);
        i_rst = 1'b0;
        seen = 1'b0;
        repeat (6) begin @(posedge i_clk); #1; if (o_valid) seen = 1'b1; end
        chk("midrst_no_valid", seen, 0);
        chk("midrst_count", o_count, 0);
        chk("midrst_ready", o_ready, 1);
        v.op = 3'd1; v.key = k("ZAP "); v.idx = 0; v.val = 0; v.e_val = 0; v.e_idx = 0;
        v.e_err = 2'd1; v.e_cnt = 0; v.e_lat = 4; v.cv = 1; v.ci = 1;
        run(v, 100);

        // i_valid held high: one accept per response
        acc = 0; strb = 0;
        @(negedge i_clk);
        i_valid = 1'b1; i_op = 3'd1; i_key = k("NONE");
        for (int c = 0; c < 10; c++) begin
            if (o_ready) acc++;
            if (o_valid) strb++;
            @(negedge i_clk);
        end
        i_valid = 1'b0;
        chk("hold_accepts", acc, 2);
        chk("hold_strobes", strb, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
